lifo_stream_reader: RTL and testbench

//  Downstream consumer of the lifo block: pops words from the LIFO read port and presents them on a

---
 rtl/lifo_stream_reader_pkg.sv | 17 +
 rtl/lifo_rd_buf.sv | 48 ++++
 rtl/lifo_stream_reader.sv | 104 ++++++++++
 tb/tb_lifo_stream_reader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_stream_reader_pkg.sv
// Shared types and sizing helpers for the LIFO stream reader.
package lifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  function automatic int buf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int BUF_DEPTH_DEF = 3;
  localparam int BUF_PTR_W     = buf_ptr_w(BUF_DEPTH_DEF);

endpackage

// File: rtl/lifo_rd_buf.sv
// Small circular FIFO that absorbs the LIFO read latency; head is read combinationally.
module lifo_rd_buf
  import lifo_stream_reader_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = BUF_DEPTH_DEF,
  parameter int PW    = BUF_PTR_W,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      // Simultaneous write and read leave the count unchanged.
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/lifo_stream_reader.sv
// Pops words from a LIFO and emits them as a framed valid/ready stream, one word per clock when
// the sink is always ready. Handshake: a beat is valid_o & ready_i; data/sop/eop hold while stalled.
module lifo_stream_reader
  import lifo_stream_reader_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int PKT_LEN_W = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 en_i,
  input  logic [PKT_LEN_W-1:0] pkt_len_i,
  output logic                 lifo_rdreq_o,
  input  logic [DWIDTH-1:0]    lifo_q_i,
  input  logic                 lifo_empty_i,
  output logic [DWIDTH-1:0]    data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic                 busy_o,
  output state_t               state_o
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = ((CW > PKT_LEN_W) ? CW : PKT_LEN_W) + 1;

  state_t               state;
  logic                 infl;
  logic [CW-1:0]        occ;
  logic [DWIDTH-1:0]    head;
  logic [PKT_LEN_W-1:0] cnt;
  logic [PKT_LEN_W-1:0] len;
  logic [PKT_LEN_W-1:0] len_in;
  logic                 beat;
  logic                 sop;
  logic                 eop;
  logic                 open_next;
  logic [SW-1:0]        pending;
  logic [SW-1:0]        remaining;

  lifo_rd_buf #(
    .DW   (DWIDTH),
    .DEPTH(BUF_DEPTH),
    .PW   (buf_ptr_w(BUF_DEPTH)),
    .CW   (CW)
  ) u_buf (
    .clk    (clk_i),
    .rst_n  (arst_n_i),
    .wr_en  (infl),
    .wr_data(lifo_q_i),
    .rd_en  (beat),
    .rd_data(head),
    .count  (occ)
  );

  assign valid_o = (occ != '0);
  assign beat    = valid_o & ready_i;
  assign len_in  = (pkt_len_i == '0) ? PKT_LEN_W'(1) : pkt_len_i;
  assign sop     = (cnt == '0);
  assign eop     = sop ? (len_in == PKT_LEN_W'(1)) : (cnt == len - 1'b1);

  // Packet still open after this cycle decides DRAIN versus IDLE when en_i falls.
  assign open_next = beat ? !eop : !sop;

  // Words buffered or in flight, and words still owed to the open packet.
  assign pending   = SW'(occ) + SW'(infl);
  assign remaining = SW'(len) - SW'(cnt);

  assign lifo_rdreq_o = (state != ST_IDLE) && !lifo_empty_i && (pending < SW'(BUF_DEPTH)) &&
                        ((state != ST_DRAIN) || (pending < remaining));

  assign data_o  = valid_o ? head : '0;
  assign sop_o   = valid_o & sop;
  assign eop_o   = valid_o & eop;
  assign busy_o  = (state != ST_IDLE) | valid_o | infl;
  assign state_o = state;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ST_IDLE;
      infl  <= 1'b0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      infl <= lifo_rdreq_o;
      if (beat) begin
        if (sop) len <= len_in;
        cnt <= eop ? '0 : cnt + 1'b1;
      end
      case (state)
        ST_IDLE:   if (en_i) state <= ST_ACTIVE;
        ST_ACTIVE: if (!en_i) state <= open_next ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: begin
          if (en_i)            state <= ST_ACTIVE;
          else if (!open_next) state <= ST_IDLE;
        end
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stream_reader.sv
// Bench for lifo_stream_reader: LIFO model with 1-cycle read latency, pop-order scoreboard and framing model.
module tb_lifo_stream_reader;
  import lifo_stream_reader_pkg::*;

  logic          clk_i = 1'b0;
  logic          arst_n_i = 1'b0;
  logic          en_i = 1'b0;
  logic [7:0]    pkt_len_i = 8'd0;
  logic          lifo_rdreq_o;
  logic [15:0]   lifo_q_i = 16'd0;
  logic          lifo_empty_i = 1'b1;
  logic [15:0]   data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          sop_o;
  logic          eop_o;
  logic          busy_o;
  state_t        state_o;

  lifo_stream_reader #(.DWIDTH(16), .BUF_DEPTH(3), .PKT_LEN_W(8)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .en_i(en_i), .pkt_len_i(pkt_len_i),
    .lifo_rdreq_o(lifo_rdreq_o), .lifo_q_i(lifo_q_i), .lifo_empty_i(lifo_empty_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .sop_o(sop_o), .eop_o(eop_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state: LIFO contents, popped-not-yet-emitted words, packet position.
  logic [15:0] stack[$];
  logic [15:0] exp_q[$];
  logic [15:0] pop_w;
  logic [15:0] w_mod;
  bit          rd_pending = 1'b0;
  int          k_mod = 0;
  int          plen_mod = 1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_sop;
  logic        prev_eop;
  int          cyc = 0;

  int          beats_n = 0, sop_n = 0, eop_n = 0, rdreq_n = 0;
  logic [15:0] log_data[$];
  bit          log_sop[$];
  bit          log_eop[$];
  int          log_cyc[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LIFO model: a request seen before the edge pops the top; q is valid for the following cycle.
  always @(posedge clk_i) begin
    if (rd_pending && arst_n_i && stack.size() != 0) begin
      pop_w = stack.pop_back();
      exp_q.push_back(pop_w);
      lifo_q_i <= pop_w;
    end
    lifo_empty_i <= (stack.size() == 0);
  end

  // Scoreboard, sampled on the falling edge.
  always @(negedge clk_i) begin
    cyc++;
    if (!arst_n_i) begin
      exp_q.delete();
      k_mod = 0;
      plen_mod = 1;
      prev_stall = 1'b0;
      rd_pending = 1'b0;
    end else begin
      rd_pending = lifo_rdreq_o;
      if (lifo_rdreq_o) begin
        rdreq_n++;
        chk("rdreq_nonempty", 32'(stack.size() != 0), 32'd1);
      end
      chk("popped_le_depth", 32'(exp_q.size() <= 3), 32'd1);
      if (prev_stall) begin
        chk("hold_valid", 32'(valid_o), 32'd1);
        chk("hold_data", 32'(data_o), 32'(prev_data));
        chk("hold_sop", 32'(sop_o), 32'(prev_sop));
        chk("hold_eop", 32'(eop_o), 32'(prev_eop));
      end
      if (valid_o && ready_i) begin
        chk("beat_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w_mod = exp_q.pop_front();
          chk("beat_data", 32'(data_o), 32'(w_mod));
        end
        if (k_mod == 0) plen_mod = (pkt_len_i == 8'd0) ? 1 : int'(pkt_len_i);
        chk("beat_sop", 32'(sop_o), 32'(k_mod == 0));
        chk("beat_eop", 32'(eop_o), 32'(k_mod == plen_mod - 1));
        k_mod = (k_mod == plen_mod - 1) ? 0 : k_mod + 1;
        beats_n++;
        if (sop_o) sop_n++;
        if (eop_o) eop_n++;
        log_data.push_back(data_o);
        log_sop.push_back(sop_o);
        log_eop.push_back(eop_o);
        log_cyc.push_back(cyc);
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_sop   = sop_o;
      prev_eop   = eop_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    beats_n = 0; sop_n = 0; eop_n = 0; rdreq_n = 0;
    log_data.delete(); log_sop.delete(); log_eop.delete(); log_cyc.delete();
  endtask

  task automatic do_reset(input bit clr);
    step();
    arst_n_i = 1'b0;
    en_i = 1'b0;
    ready_i = 1'b0;
    if (clr) stack.delete();
    repeat (2) step();
    arst_n_i = 1'b1;
  endtask

  typedef struct {
    int n_push;
    int len;
    int rmode;
    int exp_beats;
    int exp_sops;
    int exp_eops;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    int c;
    int n_pushed;

    // {words, pkt_len, ready mode (0 steady, 1 toggle, 2 random), beats, sops, eops}
    vecs[0] = '{8, 4, 0, 8, 2, 2};
    vecs[1] = '{6, 4, 1, 6, 2, 1};
    vecs[2] = '{3, 0, 0, 3, 3, 3};
    vecs[3] = '{3, 1, 1, 3, 3, 3};
    vecs[4] = '{7, 3, 2, 7, 3, 2};
    vecs[5] = '{5, 5, 0, 5, 1, 1};
    vecs[6] = '{4, 2, 1, 4, 2, 2};
    vecs[7] = '{1, 8, 2, 1, 1, 0};

    // Reset values
    repeat (3) step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("rst_sop", 32'(sop_o), 32'd0);
    chk("rst_eop", 32'(eop_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'(ST_IDLE));
    arst_n_i = 1'b1;

    // Back-to-back packets with an always-ready sink
    do_reset(1'b1);
    clear_log();
    pkt_len_i = 8'd4;
    for (int i = 1; i <= 8; i++) stack.push_back(16'(i));
    en_i = 1'b1;
    ready_i = 1'b1;
    c = 0;
    while (beats_n < 8 && c < 100) begin step(); c++; end
    repeat (4) step();
    chk("t1_beats", 32'(beats_n), 32'd8);
    chk("t1_rdreq_cycles", 32'(rdreq_n), 32'd8);
    if (beats_n >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t1_data", 32'(log_data[i]), 32'(8 - i));
        chk("t1_sop", 32'(log_sop[i]), 32'(i == 0 || i == 4));
        chk("t1_eop", 32'(log_eop[i]), 32'(i == 3 || i == 7));
      end
      chk("t1_back_to_back", 32'(log_cyc[7] - log_cyc[0]), 32'd7);
    end

    // Vector table
    for (int v = 0; v < NV; v++) begin
      do_reset(1'b1);
      clear_log();
      pkt_len_i = 8'(vecs[v].len);
      for (int i = 0; i < vecs[v].n_push; i++) stack.push_back(16'(16'h0100 * (v + 1) + i));
      en_i = 1'b1;
      ready_i = 1'b1;
      c = 0;
      while (beats_n < vecs[v].exp_beats && c < 300) begin
        step();
        c++;
        case (vecs[v].rmode)
          0:       ready_i = 1'b1;
          1:       ready_i = ~ready_i;
          default: ready_i = ($urandom_range(0, 3) != 0);
        endcase
      end
      ready_i = 1'b1;
      repeat (6) step();
      chk("vec_beats", 32'(beats_n), 32'(vecs[v].exp_beats));
      chk("vec_sops", 32'(sop_n), 32'(vecs[v].exp_sops));
      chk("vec_eops", 32'(eop_n), 32'(vecs[v].exp_eops));
      en_i = 1'b0;
    end

    // LIFO runs dry mid-packet, then refills
    do_reset(1'b1);
    clear_log();
    pkt_len_i = 8'd5;
    for (int i = 0; i < 3; i++) stack.push_back(16'(16'h0030 + i));
    en_i = 1'b1;
    ready_i = 1'b1;
    c = 0;
    while (beats_n < 3 && c < 100) begin step(); c++; end
    repeat (4) step();
    chk("t3_gap_valid", 32'(valid_o), 32'd0);
    chk("t3_gap_busy", 32'(busy_o), 32'd1);
    chk("t3_gap_state", 32'(state_o), 32'(ST_ACTIVE));
    stack.push_back(16'h0033);
    stack.push_back(16'h0034);
    c = 0;
    while (beats_n < 5 && c < 100) begin step(); c++; end
    repeat (3) step();
    chk("t3_beats", 32'(beats_n), 32'd5);
    chk("t3_sops", 32'(sop_n), 32'd1);
    if (beats_n >= 5) begin
      chk("t3_beat4_data", 32'(log_data[3]), 32'h0034);
      chk("t3_eop_beat5", 32'(log_eop[4]), 32'd1);
    end

    // en_i falls during beat 2: drain to eop without over-popping
    do_reset(1'b1);
    clear_log();
    pkt_len_i = 8'd4;
    for (int i = 0; i < 10; i++) stack.push_back(16'(16'h0040 + i));
    en_i = 1'b1;
    ready_i = 1'b1;
    c = 0;
    while (!(beats_n == 1 && valid_o && ready_i) && c < 100) begin step(); c++; end
    chk("t4_reach_beat2", 32'(beats_n == 1 && valid_o), 32'd1);
    en_i = 1'b0;
    step();
    chk("t4_state_drain", 32'(state_o), 32'(ST_DRAIN));
    repeat (20) step();
    chk("t4_beats", 32'(beats_n), 32'd4);
    chk("t4_eops", 32'(eop_n), 32'd1);
    if (beats_n >= 4) chk("t4_eop_beat4", 32'(log_eop[3]), 32'd1);
    chk("t4_state_idle", 32'(state_o), 32'(ST_IDLE));
    chk("t4_lifo_left", 32'(stack.size()), 32'd6);
    chk("t4_busy", 32'(busy_o), 32'd0);

    // Reset pulse with the buffer full
    do_reset(1'b1);
    clear_log();
    pkt_len_i = 8'd4;
    for (int i = 0; i < 10; i++) stack.push_back(16'(16'h0060 + i));
    en_i = 1'b1;
    ready_i = 1'b0;
    repeat (8) step();
    chk("t6_full_valid", 32'(valid_o), 32'd1);
    chk("t6_full_popped", 32'(stack.size()), 32'd7);
    arst_n_i = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid_o), 32'd0);
    chk("t6_rst_rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("t6_rst_sop", 32'(sop_o), 32'd0);
    chk("t6_rst_eop", 32'(eop_o), 32'd0);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) step();
    arst_n_i = 1'b1;
    ready_i = 1'b1;
    c = 0;
    while (beats_n < 4 && c < 100) begin step(); c++; end
    chk("t6_beats_after", 32'(beats_n >= 4), 32'd1);
    if (beats_n >= 4) begin
      chk("t6_first_sop", 32'(log_sop[0]), 32'd1);
      chk("t6_first_data", 32'(log_data[0]), 32'h0066);
      chk("t6_eop_beat4", 32'(log_eop[3]), 32'd1);
    end
    en_i = 1'b0;

    // Randomized rounds with pushes during streaming
    for (int r = 0; r < 6; r++) begin
      do_reset(1'b1);
      clear_log();
      pkt_len_i = 8'($urandom_range(0, 6));
      n_pushed = $urandom_range(1, 10);
      for (int i = 0; i < n_pushed; i++) stack.push_back(16'($urandom));
      en_i = 1'b1;
      c = 0;
      while ((beats_n < n_pushed || c < 40) && c < 800) begin
        step();
        c++;
        ready_i = ($urandom_range(0, 3) != 0);
        if (c < 40 && $urandom_range(0, 7) == 0) begin
          stack.push_back(16'($urandom));
          n_pushed++;
        end
      end
      chk("rand_all_emitted", 32'(beats_n), 32'(n_pushed));
      en_i = 1'b0;
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: time limit reached, beats=%0d", beats_n);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
